// File: rtl/picobus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picobus_pkg
// Description : Shared types and constants for the picobus two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package picobus_pkg;

    localparam int PORT_W       = 8;
    localparam int MASTER_IDX_W = 1;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

    // Counter load value: SETUP_CYCLES edges elapse between grant and strobe.
    function automatic logic [CNT_W-1:0] setup_load(input int setup_cycles);
        return CNT_W'(setup_cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin winner selection.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import picobus_pkg::*;
(
    input  logic        i_req0,
    input  logic        i_req1,
    input  master_idx_t i_last_served,
    output logic        o_valid,
    output master_idx_t o_winner
);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = 1'b0;
        // A tie goes to whichever master was not served last.
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_served;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/picobus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : picobus_arbiter
// Description : Two-master round-robin sequencer for the 8-bit port bus with
//               guaranteed address setup before each read/write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module picobus_arbiter
    import picobus_pkg::*;
#(
    parameter int SETUP_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [PORT_W-1:0] m0_addr,
    input  logic [PORT_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [PORT_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [PORT_W-1:0] m1_addr,
    input  logic [PORT_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [PORT_W-1:0] m1_rdata,

    output logic [PORT_W-1:0] port_id,
    output logic [PORT_W-1:0] out_port,
    output logic              write_strobe,
    input  logic [PORT_W-1:0] in_port,
    output logic              read_strobe,
    output logic              busy,
    output logic              grant
);

    localparam logic [CNT_W-1:0] c_SETUP_LOAD = setup_load(SETUP_CYCLES);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    master_idx_t       r_last;

    logic              w_valid;
    master_idx_t       w_winner;
    logic              w_sel_we;
    logic [PORT_W-1:0] w_sel_addr;
    logic [PORT_W-1:0] w_sel_wdata;

    rr_arbiter2 u_rr (
        .i_req0        (m0_req),
        .i_req1        (m1_req),
        .i_last_served (r_last),
        .o_valid       (w_valid),
        .o_winner      (w_winner)
    );

    always_comb begin
        w_sel_we    = w_winner[0] ? m1_we    : m0_we;
        w_sel_addr  = w_winner[0] ? m1_addr  : m0_addr;
        w_sel_wdata = w_winner[0] ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_last       <= 1'b1;
            port_id      <= '0;
            out_port     <= '0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            busy         <= 1'b0;
            grant        <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        grant   <= w_winner[0];
                        r_last  <= w_winner;
                        r_we    <= w_sel_we;
                        port_id <= w_sel_addr;
                        if (w_sel_we) begin
                            out_port <= w_sel_wdata;
                        end
                        r_cnt   <= c_SETUP_LOAD;
                        busy    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        write_strobe <= r_we;
                        read_strobe  <= ~r_we;
                        r_state      <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_STROBE: begin
                    // in_port is valid for the whole strobe cycle; capture at its end.
                    if (!r_we) begin
                        if (grant) begin
                            m1_rdata <= in_port;
                        end else begin
                            m0_rdata <= in_port;
                        end
                    end
                    if (grant) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    r_state <= ST_ACK;
                end

                ST_ACK: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_picobus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_picobus_arbiter
// Description : Directed scoreboard bench for picobus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picobus_arbiter;

    typedef struct {
        logic       master;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       r3_m0_req, r3_m1_req;
    logic       use_fixed;
    logic [7:0] fixed_in;
    logic [7:0] in_port;

    logic       d1_m0_ack, d1_m1_ack, d1_ws, d1_rs, d1_busy, d1_grant;
    logic [7:0] d1_m0_rdata, d1_m1_rdata, d1_port_id, d1_out_port;
    logic       d3_m0_ack, d3_m1_ack, d3_ws, d3_rs, d3_busy, d3_grant;
    logic [7:0] d3_m0_rdata, d3_m1_rdata, d3_port_id, d3_out_port;

    // In-port mux model: read data is a fixed function of the main DUT's port_id.
    assign in_port = use_fixed ? fixed_in : (d1_port_id ^ 8'h5A);

    picobus_arbiter #(.SETUP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .port_id(d1_port_id), .out_port(d1_out_port), .write_strobe(d1_ws),
        .in_port(in_port), .read_strobe(d1_rs), .busy(d1_busy), .grant(d1_grant)
    );

    picobus_arbiter #(.SETUP_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .m0_req(r3_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(r3_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .port_id(d3_port_id), .out_port(d3_out_port), .write_strobe(d3_ws),
        .in_port(in_port), .read_strobe(d3_rs), .busy(d3_busy), .grant(d3_grant)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acks = 0;
    int   last_ack_cyc = -1;
    bit   spacing_en = 1'b0;
    txn_t sb[$];
    logic [7:0] mdl_rdata [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic we, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.master = m;
        t.we     = we;
        t.addr   = a;
        t.wdata  = d;
        t.rdata  = a ^ 8'h5A;
        sb.push_back(t);
    endtask

    task automatic monitor();
        txn_t e;
        chk("strobe_exclusive", {31'b0, d1_ws & d1_rs}, 0);
        chk("ack_exclusive", {31'b0, d1_m0_ack & d1_m1_ack}, 0);
        if (d1_ws || d1_rs) begin
            chk("strobe_expected", {31'b0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk("strobe_port_id", d1_port_id, e.addr);
                chk("strobe_is_write", d1_ws, e.we);
                chk("strobe_grant", d1_grant, e.master);
                if (e.we) chk("strobe_out_port", d1_out_port, e.wdata);
            end
        end
        if (d1_m0_ack || d1_m1_ack) begin
            chk("ack_expected", {31'b0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack_master", d1_m1_ack, e.master);
                if (!e.we) mdl_rdata[e.master] = e.rdata;
            end
            chk("m0_rdata", d1_m0_rdata, mdl_rdata[0]);
            chk("m1_rdata", d1_m1_rdata, mdl_rdata[1]);
            if (spacing_en && last_ack_cyc >= 0) chk("ack_spacing", cyc - last_ack_cyc, 4);
            last_ack_cyc = cyc;
            acks++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic run_until_acks(input int target, input int max_cycles);
        int n = 0;
        while (acks < target && n < max_cycles) begin
            step();
            n++;
        end
        chk("ack_timeout", {31'b0, acks >= target}, 1);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        mdl_rdata[0] = 8'h00;
        mdl_rdata[1] = 8'h00;
        last_ack_cyc = -1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] old_addr;
        int base;
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        r3_m0_req = 0; r3_m1_req = 0;
        use_fixed = 0; fixed_in = 0;
        mdl_rdata[0] = 0; mdl_rdata[1] = 0;

        // Reset state
        step();
        step();
        chk("rst_port_id", d1_port_id, 0);
        chk("rst_out_port", d1_out_port, 0);
        chk("rst_strobes", {d1_ws, d1_rs}, 0);
        chk("rst_acks", {d1_m0_ack, d1_m1_ack}, 0);
        chk("rst_busy", d1_busy, 0);
        chk("rst_grant", d1_grant, 0);
        chk("rst_rdata", {d1_m0_rdata, d1_m1_rdata}, 0);
        chk("rst_busy3", d3_busy, 0);
        reset = 1'b0;
        step();

        // Single write, SETUP_CYCLES=1
        m0_we = 1; m0_addr = 8'h03; m0_wdata = 8'hA5; m0_req = 1;
        push(0, 1, 8'h03, 8'hA5);
        step();
        chk("wr_port_id", d1_port_id, 8'h03);
        chk("wr_out_port", d1_out_port, 8'hA5);
        chk("wr_busy", d1_busy, 1);
        chk("wr_no_strobe_e0", d1_ws, 0);
        step();
        chk("wr_strobe_e1", d1_ws, 1);
        step();
        chk("wr_ack_e2", d1_m0_ack, 1);
        chk("wr_strobe_drop", d1_ws, 0);
        m0_req = 0;
        step();
        chk("wr_ack_drop", d1_m0_ack, 0);
        chk("wr_idle", d1_busy, 0);
        step();
        step();

        // Single read, SETUP_CYCLES=3
        reset_dut();
        use_fixed = 1; fixed_in = 8'h5C;
        m1_we = 0; m1_addr = 8'h05; r3_m1_req = 1;
        step();
        chk("rd_port_id", d3_port_id, 8'h05);
        chk("rd_no_strobe_e0", d3_rs, 0);
        step();
        chk("rd_no_strobe_e1", d3_rs, 0);
        step();
        chk("rd_no_strobe_e2", d3_rs, 0);
        step();
        chk("rd_strobe_e3", d3_rs, 1);
        chk("rd_no_wstrobe", d3_ws, 0);
        step();
        chk("rd_strobe_drop", d3_rs, 0);
        chk("rd_ack_e4", d3_m1_ack, 1);
        chk("rd_m1_rdata", d3_m1_rdata, 8'h5C);
        chk("rd_m0_rdata", d3_m0_rdata, 0);
        chk("rd_m0_ack", d3_m0_ack, 0);
        r3_m1_req = 0;
        step();
        chk("rd_ack_drop", d3_m1_ack, 0);
        use_fixed = 0;

        // Contention from reset: grant order 0,1,0,1 at 4-cycle spacing
        reset_dut();
        m0_we = 0; m0_addr = 8'h12;
        m1_we = 1; m1_addr = 8'h23; m1_wdata = 8'h9E;
        push(0, 0, 8'h12, 8'h00);
        push(1, 1, 8'h23, 8'h9E);
        push(0, 0, 8'h12, 8'h00);
        push(1, 1, 8'h23, 8'h9E);
        spacing_en = 1;
        base = acks;
        m0_req = 1; m1_req = 1;
        run_until_acks(base + 4, 40);
        m0_req = 0; m1_req = 0;
        spacing_en = 0;
        step();
        step();

        // Back-to-back m0 with one IDLE cycle between ack and next port_id
        m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'h44;
        push(0, 1, 8'h30, 8'h44);
        last_ack_cyc = -1;
        spacing_en = 1;
        base = acks;
        m0_req = 1;
        for (int k = 0; k < 3; k++) begin
            run_until_acks(base + k + 1, 20);
            if (k < 2) begin
                old_addr = m0_addr;
                m0_addr = 8'(8'h31 + k);
                push(0, 1, m0_addr, 8'h44);
                step();
                chk("b2b_idle_busy", d1_busy, 0);
                chk("b2b_idle_port_id", d1_port_id, old_addr);
                step();
                chk("b2b_next_busy", d1_busy, 1);
                chk("b2b_next_port_id", d1_port_id, m0_addr);
            end
        end
        m0_req = 0;
        spacing_en = 0;
        step();
        step();

        // Reset during SETUP of a write
        reset_dut();
        m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h55; m0_req = 1;
        step();
        chk("rmid_busy", d1_busy, 1);
        chk("rmid_port_id", d1_port_id, 8'h40);
        #2 reset = 1'b1;
        #1;
        chk("rmid_async_port_id", d1_port_id, 0);
        chk("rmid_async_out_port", d1_out_port, 0);
        chk("rmid_async_busy", d1_busy, 0);
        step();
        chk("rmid_no_ack", {d1_m0_ack, d1_m1_ack}, 0);
        step();
        chk("rmid_no_strobe", {d1_ws, d1_rs}, 0);
        mdl_rdata[0] = 0; mdl_rdata[1] = 0;
        reset = 1'b0;
        m1_we = 0; m1_addr = 8'h41; m1_req = 1;
        push(0, 1, 8'h40, 8'h55);
        push(1, 0, 8'h41, 8'h00);
        step();
        chk("rmid_tie_grant", d1_grant, 0);
        chk("rmid_tie_port_id", d1_port_id, 8'h40);
        run_until_acks(acks + 2, 20);
        m0_req = 0; m1_req = 0;
        step();
        step();

        // m1 drops req during SETUP: latched fields still used
        m1_we = 1; m1_addr = 8'h66; m1_wdata = 8'h77; m1_req = 1;
        push(1, 1, 8'h66, 8'h77);
        step();
        m1_req = 0; m1_addr = 8'hFF; m1_wdata = 8'h00;
        step();
        chk("drop_strobe", d1_ws, 1);
        chk("drop_port_id", d1_port_id, 8'h66);
        chk("drop_out_port", d1_out_port, 8'h77);
        run_until_acks(acks + 1, 10);
        for (int i = 0; i < 4; i++) step();
        chk("drop_idle", d1_busy, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/picobus_arbiter.md
Name: picobus_arbiter

Overview:
- Two-master arbiter and sequencer for the 8-bit housekeeping port bus: port_id, out_port, write_strobe, in_port, read_strobe.
- Master 0 is the UART command bridge. Master 1 is a hardware sequencer, e.g. a boot-time front-end configuration loader.
- Each master issues single read or write transactions with a req/ack handshake. The block serialises them round-robin and drives the port bus with a guaranteed address setup before each strobe.
- It sits between the masters and the port decode / in_port mux logic.

Parameters:
- SETUP_CYCLES, 1, cycles port_id/out_port are held stable before the strobe (legal range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 transaction request
- m0_we  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  8  master 0 port address
- m0_wdata  in  8  master 0 write data
- m0_ack  out  1  master 0 completion pulse
- m0_rdata  out  8  master 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- port_id  out  8  port address to the port decode
- out_port  out  8  write data to the output ports
- write_strobe  out  1  one-cycle write pulse
- in_port  in  8  read data from the in_port mux (combinational on port_id)
- read_strobe  out  1  one-cycle read pulse
- busy  out  1  high whenever state is not IDLE
- grant  out  1  index of the master currently or most recently served

Behaviour:
- Reset (asynchronous, any time):
  - port_id, out_port, m0_rdata, m1_rdata = 0.
  - write_strobe, read_strobe, m0_ack, m1_ack, busy = 0.
  - grant = 0; internal last-served = 1, so master 0 wins the first tie.
  - State = IDLE; setup counter = 0.
  - An in-flight transaction is aborted: no strobe, no ack.
- All outputs are registered.
- State machine: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the master not last served.
  - On the grant edge: latch we/addr/wdata of the winner, drive port_id <= addr, out_port <= wdata (writes only; out_port unchanged on reads), update grant, load counter = SETUP_CYCLES-1, go to SETUP.
- SETUP: hold all bus outputs; decrement the counter. When the counter is 0, go to STROBE with write_strobe = we or read_strobe = !we.
- STROBE:
  - The strobe is high for exactly this one cycle.
  - On a read, in_port is captured at the edge ending this cycle into the granted master's rdata.
  - Go to ACK; the strobe drops.
- ACK: the granted master's ack is high for exactly one cycle; go to IDLE.
- Latency: the req-sampling edge is E0.
  - port_id is valid after E0.
  - The strobe is high in the cycle after E0+SETUP_CYCLES.
  - Ack is high in the following cycle.
  - Back-to-back spacing is SETUP_CYCLES+3 cycles per transaction.
- Handshake:
  - A master holds req and its request fields until it samples ack.
  - A master clearing req on the ack-sampling edge gets no duplicate transaction.
  - A master keeping req high gets a new transaction; rotation still applies.
  - req dropped before ack (protocol violation): the transaction still completes from the latched fields and ack still pulses.
- Request fields of the non-granted master are ignored while busy.
- rdata of each master holds until that master's next read completes. Writes do not modify rdata.
- port_id and out_port hold their last values between transactions.
- write_strobe and read_strobe are never high together, and never both masters' acks.

Decomposition:
- Package picobus_pkg: state encoding (IDLE, SETUP, STROBE, ACK), PORT_W = 8, MASTER_IDX width.
- Sub-module rr_arbiter2: combinational two-way round-robin winner selection from req pair and last-served bit.

Test Plan:
- Single write: m0 write addr 0x03 data 0xA5, SETUP_CYCLES=1 -> port_id=0x03 and out_port=0xA5 after E0; write_strobe one cycle at E0+1; m0_ack at E0+2; read_strobe never high.
- Single read: m1 read addr 0x05 with in_port=0x5C, SETUP_CYCLES=3 -> read_strobe one cycle at E0+3; m1_rdata=0x5C with m1_ack at E0+4; m0_rdata unchanged at 0.
- Contention: both req from reset, held through several acks -> grant order 0,1,0,1; each ack at 4-cycle spacing; no ack overlap.
- Back-to-back: m0 keeps req high with m1 idle -> consecutive m0 transactions with exactly one IDLE cycle between ack and the next port_id update.
- Reset mid-operation: assert reset during SETUP of a write -> outputs zero asynchronously; no write_strobe, no ack; after release, first tie goes to m0.
- req drop: m1 drops req in SETUP -> strobe and m1_ack still occur with the latched addr/data.
